axi_write_port_arbiter: RTL

- Shares the single AXI4 write port (AW/W/B) of axi_simple_dual_port_ram between two AXI4 write masters.
- Round-robin grant. A grant is held for one complete transaction (AW, then all W beats, then B); one transaction is outstanding at a time.
- Checks each granted burst's WLAST position against the latched AWLEN and reports a sticky error.
- Sits between the two master write-channel controllers and the RAM DUT in the Part13-style bench and SoC wrappers.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/axi_write_port_arbiter_rr.sv | 14 +
 rtl/axi_write_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM state, burst and response encodings for the write-port arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } arb_state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_write_port_arbiter_rr.sv
// axi_rr_arbiter_2: combinational two-input round-robin pick, favouring the master not served last
module axi_rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ~rr_last : req[1];
    end

endmodule

// File: rtl/axi_write_port_arbiter.sv
// axi_write_port_arbiter: shares one AXI4 write port between two masters, one whole transaction per grant
module axi_write_port_arbiter #(
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 32,
    parameter  int AXI_ID_WIDTH   = 8,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                          axi_clk,
    input  logic                          axi_resetn,
    input  logic [2*AXI_ADDR_WIDTH-1:0]   s_aw_addr,
    input  logic [3:0]                    s_aw_burst,
    input  logic [5:0]                    s_aw_size,
    input  logic [2*AXI_ID_WIDTH-1:0]     s_aw_id,
    input  logic [15:0]                   s_aw_len,
    input  logic [1:0]                    s_aw_valid,
    output logic [1:0]                    s_aw_ready,
    input  logic [2*AXI_DATA_WIDTH-1:0]   s_w_data,
    input  logic [2*AXI_STRB_WIDTH-1:0]   s_w_strb,
    input  logic [1:0]                    s_w_last,
    input  logic [1:0]                    s_w_valid,
    output logic [1:0]                    s_w_ready,
    output logic [1:0]                    s_b_resp,
    output logic [AXI_ID_WIDTH-1:0]       s_b_id,
    output logic [1:0]                    s_b_valid,
    input  logic [1:0]                    s_b_ready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_aw_addr,
    output logic [1:0]                    m_aw_burst,
    output logic [2:0]                    m_aw_size,
    output logic [AXI_ID_WIDTH-1:0]       m_aw_id,
    output logic [7:0]                    m_aw_len,
    output logic                          m_aw_valid,
    input  logic                          m_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]     m_w_data,
    output logic [AXI_STRB_WIDTH-1:0]     m_w_strb,
    output logic                          m_w_last,
    output logic                          m_w_valid,
    input  logic                          m_w_ready,
    input  logic [1:0]                    m_b_resp,
    input  logic [AXI_ID_WIDTH-1:0]       m_b_id,
    input  logic                          m_b_valid,
    output logic                          m_b_ready,
    output logic                          grant_idx,
    output logic                          busy,
    output logic                          wlast_err
);
    import axi_arb_pkg::*;

    arb_state_e state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       grant_q, grant_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [7:0] len_q, len_d;
    logic       wlast_err_q, wlast_err_d;
    logic       gnt_idx, gnt_valid;

    logic [AXI_ADDR_WIDTH-1:0] aw_addr_g;
    logic [1:0]                aw_burst_g;
    logic [2:0]                aw_size_g;
    logic [AXI_ID_WIDTH-1:0]   aw_id_g;
    logic [7:0]                aw_len_g;
    logic [AXI_DATA_WIDTH-1:0] w_data_g;
    logic [AXI_STRB_WIDTH-1:0] w_strb_g;
    logic                      aw_valid_g, w_valid_g, w_last_g, b_ready_g;

    axi_rr_arbiter_2 u_rr (
        .req       (s_aw_valid),
        .rr_last   (rr_last_q),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Granted master's channel payloads
    assign aw_addr_g  = grant_q ? s_aw_addr[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH] : s_aw_addr[AXI_ADDR_WIDTH-1:0];
    assign aw_burst_g = grant_q ? s_aw_burst[3:2] : s_aw_burst[1:0];
    assign aw_size_g  = grant_q ? s_aw_size[5:3] : s_aw_size[2:0];
    assign aw_id_g    = grant_q ? s_aw_id[2*AXI_ID_WIDTH-1:AXI_ID_WIDTH] : s_aw_id[AXI_ID_WIDTH-1:0];
    assign aw_len_g   = grant_q ? s_aw_len[15:8] : s_aw_len[7:0];
    assign w_data_g   = grant_q ? s_w_data[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH] : s_w_data[AXI_DATA_WIDTH-1:0];
    assign w_strb_g   = grant_q ? s_w_strb[2*AXI_STRB_WIDTH-1:AXI_STRB_WIDTH] : s_w_strb[AXI_STRB_WIDTH-1:0];
    assign aw_valid_g = s_aw_valid[grant_q];
    assign w_valid_g  = s_w_valid[grant_q];
    assign w_last_g   = s_w_last[grant_q];
    assign b_ready_g  = s_b_ready[grant_q];

    assign grant_idx = grant_q;
    assign busy      = state_q != ST_IDLE;
    assign wlast_err = wlast_err_q;

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        wlast_err_d = wlast_err_q;
        s_aw_ready  = '0;
        s_w_ready   = '0;
        s_b_valid   = '0;
        s_b_resp    = '0;
        s_b_id      = '0;
        m_aw_addr   = '0;
        m_aw_burst  = '0;
        m_aw_size   = '0;
        m_aw_id     = '0;
        m_aw_len    = '0;
        m_aw_valid  = 1'b0;
        m_w_data    = '0;
        m_w_strb    = '0;
        m_w_last    = 1'b0;
        m_w_valid   = 1'b0;
        m_b_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_aw_addr           = aw_addr_g;
                m_aw_burst          = aw_burst_g;
                m_aw_size           = aw_size_g;
                m_aw_id             = aw_id_g;
                m_aw_len            = aw_len_g;
                m_aw_valid          = aw_valid_g;
                s_aw_ready[grant_q] = m_aw_ready;
                if (aw_valid_g && m_aw_ready) begin
                    len_d      = aw_len_g;
                    beat_cnt_d = '0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                m_w_data           = w_data_g;
                m_w_strb           = w_strb_g;
                m_w_last           = w_last_g;
                m_w_valid          = w_valid_g;
                s_w_ready[grant_q] = m_w_ready;
                if (w_valid_g && m_w_ready) begin
                    beat_cnt_d = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
                    // Early last and missing last both flag; the beat is forwarded regardless
                    if (w_last_g ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q))
                        wlast_err_d = 1'b1;
                    state_d = w_last_g ? ST_RESP : ST_DATA;
                end
            end
            ST_RESP: begin
                m_b_ready          = b_ready_g;
                s_b_valid[grant_q] = m_b_valid;
                s_b_resp           = m_b_resp;
                s_b_id             = m_b_id;
                if (m_b_valid && b_ready_g) begin
                    rr_last_d = grant_q;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            grant_q     <= 1'b0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            wlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            wlast_err_q <= wlast_err_d;
        end
    end

endmodule
